// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU/shifter ops,
// datapath mux selects, instruction classes and condition codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [2:0] SH_LSL  = 3'b000;
  localparam logic [2:0] SH_LSR  = 3'b001;
  localparam logic [2:0] SH_ASR  = 3'b010;
  localparam logic [2:0] SH_ROR  = 3'b011;
  localparam logic [2:0] SH_NONE = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic cmd_defined(input logic [3:0] cmd);
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] cmd_aluop(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      CMD_MOV:          return ALU_MOV;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR/flags in, all datapath controls out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [31:0] INSTRUCTION;
  logic [3:0]  FLAGS;
  logic        A3Src;
  logic        AdrSrc;
  logic        FlagUpdate;
  logic        IRWrite;
  logic        MemWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        WD3Src;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  RegSrc;
  logic [2:0]  ALUop;
  logic [2:0]  ShiftType;
  logic        halted;

  modport master (
    input  INSTRUCTION, FLAGS,
    output A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
    output ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, halted
  );

  modport slave (
    output INSTRUCTION, FLAGS,
    input  A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
    input  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, halted
  );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// Combinational condition-code evaluator; flags_i is {N,Z,C,V}.
module multicycle_controller_cond_check
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle computer. Define CTRL_ILLEGAL_TRAP_EN to
// trap undefined encodings in a HALT state instead of retiring them as NOPs.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  multicycle_controller_if.master        dp,
  output state_e                         state_o
);
  state_e state_q, state_d;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       imm_bit, s_bit, u_bit, l_bit, link_bit;
  logic       cond_pass, cmd_ok, illegal;
  logic       unused_instr_bits;

  assign cond     = dp.INSTRUCTION[31:28];
  assign op       = dp.INSTRUCTION[27:26];
  assign imm_bit  = dp.INSTRUCTION[25];
  assign cmd      = dp.INSTRUCTION[24:21];
  assign link_bit = dp.INSTRUCTION[24];
  assign u_bit    = dp.INSTRUCTION[23];
  assign s_bit    = dp.INSTRUCTION[20];
  assign l_bit    = dp.INSTRUCTION[20];
  assign unused_instr_bits = ^{dp.INSTRUCTION[19:7], dp.INSTRUCTION[4:0]};

  multicycle_controller_cond_check u_cond_check (
    .cond_i  (cond),
    .flags_i (dp.FLAGS),
    .pass_o  (cond_pass)
  );

  assign cmd_ok = cmd_defined(cmd);

  // With the trap enabled an illegal encoding halts even if its condition
  // would fail; cond=1111 is then treated as illegal rather than "never".
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_e TRAP_STATE = S_HALT;
  assign illegal = (op == 2'b11) || ((op == OP_DP) && !cmd_ok) || (cond == COND_NV);
`else
  localparam state_e TRAP_STATE = S_FETCH;
  assign illegal = (op == 2'b11) || ((op == OP_DP) && !cmd_ok);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d       = state_q;
    dp.A3Src      = 1'b0;
    dp.AdrSrc     = 1'b0;
    dp.FlagUpdate = 1'b0;
    dp.IRWrite    = 1'b0;
    dp.MemWrite   = 1'b0;
    dp.PCWrite    = 1'b0;
    dp.RegWrite   = 1'b0;
    dp.WD3Src     = 1'b0;
    dp.ALUSrcA    = SRCA_PC;
    dp.ALUSrcB    = SRCB_REG;
    dp.ResultSrc  = RES_ALUOUT;
    dp.RegSrc     = 2'b00;
    dp.ALUop      = ALU_ADD;
    dp.ShiftType  = SH_NONE;
    dp.halted     = 1'b0;
    // Reset masks every output in the same cycle so no partial write escapes.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          dp.IRWrite   = 1'b1;
          dp.PCWrite   = 1'b1;
          dp.ALUSrcB   = SRCB_FOUR;
          dp.ResultSrc = RES_ALU;
          state_d      = S_DECODE;
        end
        S_DECODE: begin
          dp.RegSrc  = {op == OP_MEM, op == OP_BR};
          dp.ALUSrcA = SRCA_REG;
          dp.ALUSrcB = SRCB_IMM;
          if (illegal)         state_d = TRAP_STATE;
          else if (!cond_pass) state_d = S_FETCH;
          else if (op == OP_BR)  state_d = S_BRANCH;
          else if (op == OP_MEM) state_d = S_MEMADR;
          else                   state_d = imm_bit ? S_EXECI : S_EXECR;
        end
        S_EXECR, S_EXECI: begin
          dp.ALUSrcA    = SRCA_REG;
          dp.ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
          dp.ALUop      = cmd_aluop(cmd);
          dp.FlagUpdate = s_bit;
          if ((state_q == S_EXECR) && (cmd == CMD_MOV))
            dp.ShiftType = {1'b0, dp.INSTRUCTION[6:5]};
          state_d = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
        end
        S_ALUWB: begin
          dp.RegWrite = 1'b1;
          state_d     = S_FETCH;
        end
        S_MEMADR: begin
          dp.ALUSrcA = SRCA_REG;
          dp.ALUSrcB = SRCB_IMM;
          dp.ALUop   = u_bit ? ALU_ADD : ALU_SUB;
          state_d    = l_bit ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          dp.AdrSrc = 1'b1;
          state_d   = S_MEMWB;
        end
        S_MEMWB: begin
          dp.RegWrite  = 1'b1;
          dp.ResultSrc = RES_DATA;
          state_d      = S_FETCH;
        end
        S_MEMWR: begin
          dp.MemWrite = 1'b1;
          dp.AdrSrc   = 1'b1;
          dp.RegSrc   = 2'b10;
          state_d     = S_FETCH;
        end
        S_BRANCH: begin
          dp.PCWrite   = 1'b1;
          dp.ALUSrcA   = SRCA_REG;
          dp.ALUSrcB   = SRCB_IMM;
          dp.ResultSrc = RES_ALU;
          if (link_bit) begin
            dp.RegWrite = 1'b1;
            dp.A3Src    = 1'b1;
            dp.WD3Src   = 1'b1;
          end
          state_d = S_FETCH;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT: begin
          dp.halted = 1'b1;
          state_d   = S_HALT;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule
